// File: rtl/amm_cfg_master_if.sv
// Avalon-MM bus bundle shared by the config master and the target register map.
// The master drives the command side; the slave drives the response side.
interface avalon_mm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  read;
    logic                  waitrequest;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address, write, writedata, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, write, writedata, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/amm_cfg_master.sv
// Loads a pattern into a small Avalon-MM register map with control bit 0 held off
// during the load, then optionally reads everything back and flags the first bad address.
module amm_cfg_master #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_DEPTH  = 3,
    parameter int ADDR_WIDTH = REG_DEPTH + 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    avalon_mm_if.master                          amm_master_if,
    input  logic                                 start_i,
    input  logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] pattern_i,
    input  logic                                 enable_i,
    input  logic                                 verify_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [ADDR_WIDTH-1:0]                fail_addr_o
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;

    localparam int                    TW      = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WR = ADDR_WIDTH'(REG_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_RD = ADDR_WIDTH'(REG_DEPTH);
    localparam logic [TW-1:0]         T_MAX   = TW'(TIMEOUT - 1);

    state_t                               state, state_nx;
    logic [ADDR_WIDTH-1:0]                idx;
    logic [TW-1:0]                        tcnt;
    logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] pat_q;
    logic                                 enable_q, verify_q;
    logic                                 error_q;
    logic [ADDR_WIDTH-1:0]                fail_q;

    logic [ADDR_WIDTH-1:0] word_idx, beat_addr;
    logic [DATA_WIDTH-1:0] pat_word, beat_data;
    logic                  is_ctrl, wait_req, rd_vld, mismatch, tmo;

    assign wait_req = amm_master_if.waitrequest;
    assign rd_vld   = amm_master_if.readdatavalid;

    // Beat index -> address/value. Write beats are ctrl, pattern..., ctrl; read beats
    // are pattern..., ctrl. The same mapping gives the expected readback value.
    always_comb begin
        word_idx = (state == WRITE) ? idx - ADDR_WIDTH'(1) : idx;
        pat_word = '0;
        for (int k = 0; k < REG_DEPTH; k++)
            if (word_idx == ADDR_WIDTH'(k)) pat_word = pat_q[k];
        is_ctrl   = (state == WRITE) ? (idx == '0 || idx == LAST_WR) : (idx == LAST_RD);
        beat_addr = is_ctrl ? '0 : ((state == WRITE) ? idx : idx + ADDR_WIDTH'(1));
        if (state == WRITE && idx == '0) beat_data = '0;
        else if (is_ctrl)                beat_data = {{(DATA_WIDTH-1){1'b0}}, enable_q};
        else                             beat_data = pat_word;
    end

    assign mismatch = (state == WAIT_RD) && rd_vld && (amm_master_if.readdata != beat_data);
    assign tmo      = (state == WAIT_RD) && !rd_vld && (tcnt == T_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = WRITE;
            WRITE:   if (!wait_req && idx == LAST_WR) state_nx = verify_q ? READ : DONE;
            READ:    if (!wait_req) state_nx = WAIT_RD;
            WAIT_RD: begin
                if (rd_vld)   state_nx = (idx == LAST_RD) ? DONE : READ;
                else if (tmo) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        amm_master_if.write     = (state == WRITE);
        amm_master_if.read      = (state == READ);
        amm_master_if.address   = (state == WRITE || state == READ) ? beat_addr : '0;
        amm_master_if.writedata = (state == WRITE) ? beat_data : '0;
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
        error_o     = error_q;
        fail_addr_o = fail_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx      <= '0;
            tcnt     <= '0;
            pat_q    <= '0;
            enable_q <= 1'b0;
            verify_q <= 1'b0;
            error_q  <= 1'b0;
            fail_q   <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                pat_q    <= pattern_i;
                enable_q <= enable_i;
                verify_q <= verify_i;
                error_q  <= 1'b0;
                fail_q   <= '0;
                idx      <= '0;
            end
            if (state == WRITE && !wait_req)
                idx <= (idx == LAST_WR) ? '0 : idx + ADDR_WIDTH'(1);
            if (state == WAIT_RD && rd_vld)
                idx <= idx + ADDR_WIDTH'(1);
            tcnt <= (state == WAIT_RD && !rd_vld) ? tcnt + TW'(1) : '0;
            // Only the first failure is recorded; later mismatches keep the readback going.
            if ((mismatch || tmo) && !error_q) begin
                error_q <= 1'b1;
                fail_q  <= beat_addr;
            end
        end
    end

endmodule

// File: tb/tb_amm_cfg_master.sv
// Directed bench for amm_cfg_master: table of load/verify scenarios against a small
// register-map slave, plus hand sequences for reset abort and ignored starts.
module tb_amm_cfg_master;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              start_i = 1'b0;
    logic [2:0][31:0]  pattern_i = '0;
    logic              enable_i = 1'b0;
    logic              verify_i = 1'b0;
    logic              busy_o, done_o, error_o;
    logic [3:0]        fail_addr_o;

    avalon_mm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    amm_cfg_master dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .amm_master_if(bus),
        .start_i(start_i), .pattern_i(pattern_i), .enable_i(enable_i), .verify_i(verify_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .fail_addr_o(fail_addr_o)
    );

    always #5 clk_i = ~clk_i;

    // slave configuration
    logic [3:0]  wait_addr = 4'hF;
    int          wait_n = 0;
    logic [15:0] corrupt = '0;
    logic [3:0]  nordv = 4'hF;

    logic [31:0] mem [16];
    int          stall_cnt = 0;

    assign bus.waitrequest = bus.write && (bus.address == wait_addr) && (stall_cnt < wait_n);

    always @(posedge clk_i) begin
        bus.readdatavalid <= 1'b0;
        if (!busy_o) stall_cnt <= 0;
        else if (bus.write && bus.address == wait_addr && stall_cnt < wait_n) stall_cnt <= stall_cnt + 1;
        if (bus.write && !bus.waitrequest) mem[bus.address] <= bus.writedata;
        if (bus.read && !bus.waitrequest && bus.address != nordv) begin
            bus.readdatavalid <= 1'b1;
            bus.readdata <= mem[bus.address] ^ (corrupt[bus.address] ? 32'h0000_0100 : 32'h0);
        end
    end

    // monitor: cycle numbers label the cycle ending at the sampling edge
    int          cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, a2_hits = 0;
    logic [35:0] wr_log[$];
    int          wr_cyc[$];
    logic [3:0]  rd_log[$];

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_n_i && start_i && !busy_o) start_cyc <= cyc;
        if (done_o) begin
            done_cyc <= cyc;
            done_cnt <= done_cnt + 1;
        end
        if (bus.write && !bus.waitrequest) begin
            wr_log.push_back({bus.address, bus.writedata});
            wr_cyc.push_back(cyc);
        end
        if (bus.read && !bus.waitrequest) rd_log.push_back(bus.address);
        if (bus.write && bus.address == 4'd2 && bus.writedata == pattern_i[1]) a2_hits <= a2_hits + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wr_log.delete(); wr_cyc.delete(); rd_log.delete();
    endtask

    task automatic wait_done(input string name);
        int prev = done_cnt;
        int k = 0;
        while (done_cnt == prev && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt != prev), 64'd1);
    endtask

    typedef struct {
        logic [31:0] p0, p1, p2;
        logic        en, ver;
        logic [3:0]  wait_addr;
        int          wait_n;
        logic [15:0] corrupt;
        logic [3:0]  nordv;
        int          lat;
        logic        err;
        logic [3:0]  fail;
        int          nrd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [3:0]  rd_exp[4];
        logic [35:0] wexp[5];
        logic        prev_err;
        logic [3:0]  prev_fail;
        int          wr_base;
        string       nm;

        rd_exp = '{4'd1, 4'd2, 4'd3, 4'd0};
        //            p0            p1            p2            en    ver   wa    wn cor      nrdv  lat err   fail  nrd
        vecs[0] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 1'b1, 1'b0, 4'hF, 0, 16'h0,  4'hF, 6,  1'b0, 4'd0, 0};
        vecs[1] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 1'b1, 1'b1, 4'hF, 0, 16'h0,  4'hF, 14, 1'b0, 4'd0, 4};
        vecs[2] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 1'b1, 1'b0, 4'd2, 3, 16'h0,  4'hF, 9,  1'b0, 4'd0, 0};
        vecs[3] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 1'b1, 1'b1, 4'hF, 0, 16'h000C, 4'hF, 14, 1'b1, 4'd2, 4};
        vecs[4] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 1'b1, 1'b1, 4'hF, 0, 16'h0,  4'd1, 23, 1'b1, 4'd1, 1};
        vecs[5] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd0, 2, 16'h0,  4'hF, 16, 1'b0, 4'd0, 4};

        // reset state
        #1;
        chk("rst_write", 64'(bus.write), 0);
        chk("rst_read", 64'(bus.read), 0);
        chk("rst_addr", 64'(bus.address), 0);
        chk("rst_wdata", 64'(bus.writedata), 0);
        chk("rst_flags", 64'({busy_o, done_o, error_o, fail_addr_o}), 0);
        @(negedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        prev_err = 1'b0; prev_fail = '0;
        foreach (vecs[i]) begin
            nm = $sformatf("v%0d", i);
            chk({nm, "_hold_err"}, 64'({error_o, fail_addr_o}), 64'({prev_err, prev_fail}));
            wait_addr = vecs[i].wait_addr; wait_n = vecs[i].wait_n;
            corrupt = vecs[i].corrupt;     nordv = vecs[i].nordv;
            pattern_i = {vecs[i].p2, vecs[i].p1, vecs[i].p0};
            enable_i = vecs[i].en; verify_i = vecs[i].ver;
            clear_logs();
            wr_base = a2_hits;
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            chk({nm, "_start_clr"}, 64'({busy_o, error_o, fail_addr_o}), 64'({1'b1, 1'b0, 4'd0}));
            wait_done(nm);
            @(negedge clk_i);
            chk({nm, "_done_1cyc"}, 64'({done_o, busy_o}), 0);
            chk({nm, "_latency"}, 64'(done_cyc - start_cyc), 64'(vecs[i].lat));
            chk({nm, "_err"}, 64'({error_o, fail_addr_o}), 64'({vecs[i].err, vecs[i].fail}));
            wexp = '{{4'd0, 32'h0}, {4'd1, vecs[i].p0}, {4'd2, vecs[i].p1},
                     {4'd3, vecs[i].p2}, {4'd0, 31'h0, vecs[i].en}};
            chk({nm, "_nwr"}, 64'(wr_log.size()), 5);
            for (int k = 0; k < 5 && k < wr_log.size(); k++) begin
                chk($sformatf("%s_wr%0d", nm, k), 64'(wr_log[k]), 64'(wexp[k]));
                if (vecs[i].wait_n == 0)
                    chk($sformatf("%s_wrcyc%0d", nm, k), 64'(wr_cyc[k]), 64'(start_cyc + 1 + k));
            end
            chk({nm, "_a2_stable"}, 64'(a2_hits - wr_base),
                64'(1 + ((vecs[i].wait_addr == 4'd2) ? vecs[i].wait_n : 0)));
            chk({nm, "_nrd"}, 64'(rd_log.size()), 64'(vecs[i].nrd));
            for (int k = 0; k < 4 && k < rd_log.size(); k++)
                chk($sformatf("%s_rd%0d", nm, k), 64'(rd_log[k]), 64'(rd_exp[k]));
            prev_err = vecs[i].err; prev_fail = vecs[i].fail;
            repeat (3) @(negedge clk_i);
        end
        wait_addr = 4'hF; wait_n = 0; corrupt = '0; nordv = 4'hF;

        // start in the DONE cycle is dropped
        verify_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 20 && !done_o; k++) @(negedge clk_i);
        chk("dn_in_done", 64'(done_o), 1);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("dn_idle_after", 64'(busy_o), 0);
        clear_logs();
        repeat (6) @(negedge clk_i);
        chk("dn_no_beats", 64'(wr_log.size() + rd_log.size()), 0);

        // reset mid-write, with a start while busy beforehand
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 20 && !(bus.write && bus.address == 4'd3); k++) @(negedge clk_i);
        chk("r6_at_addr3", 64'({bus.write, bus.address}), 64'({1'b1, 4'd3}));
        rst_n_i = 1'b0;
        #1;
        chk("r6_bus_zero", 64'({bus.write, bus.read, bus.address, bus.writedata}), 0);
        chk("r6_flags_zero", 64'({busy_o, done_o, error_o, fail_addr_o}), 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        clear_logs();
        repeat (8) @(negedge clk_i);
        chk("r6_no_beats", 64'(wr_log.size() + rd_log.size()), 0);
        chk("r6_idle", 64'(busy_o), 0);

        // start accepted on the first edge after reset release
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("r17_busy", 64'(busy_o), 1);
        wait_done("r17");
        chk("r17_latency", 64'(done_cyc - start_cyc), 6);
        @(negedge clk_i);
        chk("r17_nwr", 64'(wr_log.size()), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
